// File: rtl/rriot_pkg.sv
// Shared types and widths for the RRIOT bus arbiter and its neighbours.
package rriot_pkg;

   localparam int RRIOT_AW = 10;
   localparam int RRIOT_DW = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

endpackage

// File: rtl/rriot_bus_arbiter.sv
// Single-port arbiter in front of an mcs6530: CPU has priority, a starvation
// counter steals one CPU read slot via RDY, and late read data is routed back.
module rriot_bus_arbiter
   import rriot_pkg::*;
#(
   parameter int unsigned             STARVE_LIMIT = 15,
   parameter logic [RRIOT_DW-1:0]     IDLE_DATA    = 8'hFF
) (
   input  logic                phi2,
   input  logic                rst_n,
   input  logic                cpu_sel,
   input  logic                cpu_we_n,
   input  logic [RRIOT_AW-1:0] cpu_a,
   input  logic [RRIOT_DW-1:0] cpu_di,
   output logic [RRIOT_DW-1:0] cpu_do,
   output logic                cpu_rdy,
   input  logic                host_req,
   input  logic                host_we_n,
   input  logic [RRIOT_AW-1:0] host_a,
   input  logic [RRIOT_DW-1:0] host_wdata,
   output logic                host_ack,
   output logic                host_rvalid,
   output logic [RRIOT_DW-1:0] host_rdata,
   output logic                dev_cs,
   output logic                dev_we_n,
   output logic [RRIOT_AW-1:0] dev_a,
   output logic [RRIOT_DW-1:0] dev_di,
   input  logic [RRIOT_DW-1:0] dev_do,
   input  logic                dev_oe
);

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   owner_t              owner;
   owner_t              rd_own_q;
   logic                force_grant;
   logic [7:0]          starve_cnt;
   logic [7:0]          starve_cnt_next;
   logic [RRIOT_DW-1:0] rd_data;
   logic                host_rvalid_q;

   // Grants are suppressed entirely while reset is held.
   always_comb begin
      owner       = OWN_NONE;
      force_grant = 1'b0;
      if (rst_n) begin
         force_grant = host_req & cpu_sel & cpu_we_n & (starve_cnt == STARVE_MAX);
         if (force_grant)
            owner = OWN_HOST;
         else if (cpu_sel)
            owner = OWN_CPU;
         else if (host_req)
            owner = OWN_HOST;
      end
   end

   always_comb begin
      dev_cs   = 1'b0;
      dev_we_n = 1'b1;
      dev_a    = '0;
      dev_di   = '0;
      case (owner)
         OWN_CPU: begin
            dev_cs   = 1'b1;
            dev_we_n = cpu_we_n;
            dev_a    = cpu_a;
            dev_di   = cpu_di;
         end
         OWN_HOST: begin
            dev_cs   = 1'b1;
            dev_we_n = host_we_n;
            dev_a    = host_a;
            dev_di   = host_wdata;
         end
         default: ;
      endcase
   end

   assign cpu_rdy     = ~force_grant;
   assign host_ack    = (owner == OWN_HOST);
   assign host_rvalid = host_rvalid_q;
   assign rd_data     = dev_oe ? dev_do : IDLE_DATA;

   // Saturates rather than wraps so a run of CPU writes keeps the host due.
   always_comb begin
      starve_cnt_next = starve_cnt;
      if (!host_req || owner == OWN_HOST)
         starve_cnt_next = 8'd0;
      else if (starve_cnt != STARVE_MAX)
         starve_cnt_next = starve_cnt + 8'd1;
   end

   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt    <= 8'd0;
         rd_own_q      <= OWN_NONE;
         cpu_do        <= '0;
         host_rdata    <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         starve_cnt    <= starve_cnt_next;
         rd_own_q      <= (owner != OWN_NONE && dev_we_n) ? owner : OWN_NONE;
         host_rvalid_q <= (rd_own_q == OWN_HOST);
         if (rd_own_q == OWN_CPU)
            cpu_do <= rd_data;
         if (rd_own_q == OWN_HOST)
            host_rdata <= rd_data;
      end
   end

endmodule

// File: doc/rriot_bus_arbiter.md
# rriot_bus_arbiter

Single-port access arbiter placed in front of one `mcs6530` (RRIOT) instance. It shares the device's register/RAM/ROM port between the 6502 CPU and a host requester, such as a debug bridge or loader. The CPU has priority. A starvation counter may steal one CPU read slot, via `cpu_rdy`, so the host always makes progress. The arbiter also routes the device's one-cycle-late read data back to whichever requester issued the read.

## Interface
Parameters:
- `STARVE_LIMIT`, default 15: consecutive denied host-pending cycles before a forced host grant (legal range 1..255).
- `IDLE_DATA`, default 8'hFF: value returned when the device does not drive `dev_oe`.

Ports:
- `phi2` in 1: the only clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_sel` in 1: the CPU addresses this device this cycle.
- `cpu_we_n` in 1: CPU read high / write low.
- `cpu_a` in 10: CPU address.
- `cpu_di` in 8: CPU write data.
- `cpu_do` out 8: CPU read data, registered.
- `cpu_rdy` out 1: 6502 RDY; low stalls the CPU read.
- `host_req` in 1: host access request; held until `host_ack`.
- `host_we_n` in 1: host read high / write low.
- `host_a` in 10: host address.
- `host_wdata` in 8: host write data.
- `host_ack` out 1: pulses in the granted slot.
- `host_rvalid` out 1: pulses one cycle after a granted host read.
- `host_rdata` out 8: host read data, valid while `host_rvalid` is high.
- `dev_cs` out 1: device access enable; integration maps it to CS1/RS_n.
- `dev_we_n` out 1: write strobe to the device.
- `dev_a` out 10: address to the device.
- `dev_di` out 8: write data to the device.
- `dev_do` in 8: device read data.
- `dev_oe` in 1: the device is driving `dev_do`.

## Operation
- **Slots.** Each `phi2` cycle is one slot. The slot owner is decided combinationally from the current inputs and the registered starvation count. The `dev_*` outputs are a combinational mux of the owner's fields.
- **Owner selection.**
  - `force` = `host_req` & `cpu_sel` & `cpu_we_n` & (`starve_cnt` == `STARVE_LIMIT`).
  - `force` → owner HOST, `cpu_rdy`=0. This is the only condition that drives `cpu_rdy` low.
  - else `cpu_sel` → owner CPU.
  - else `host_req` → owner HOST.
  - else owner NONE: `dev_cs`=0, `dev_we_n`=1, `dev_a`=0, `dev_di`=0.
- **CPU writes.** A CPU write slot is never stolen, because the NMOS 6502 ignores RDY on writes. The counter stays saturated and the host is granted in the first CPU-read or idle slot.
- **`host_ack`.** Equals (owner == HOST); it is combinational.
- **Starvation counter `starve_cnt`** (8 bit):
  - cleared when `host_req`=0 or on any host grant;
  - otherwise incremented, saturating at `STARVE_LIMIT`.
- **Pending-read register.** `rd_own_q` ∈ {NONE, CPU, HOST} records the owner of a read slot; a write or idle slot sets it to NONE.
  - Next cycle, with `rd` = `dev_oe` ? `dev_do` : `IDLE_DATA`:
    - CPU → `cpu_do` ← `rd`;
    - HOST → `host_rdata` ← `rd` and `host_rvalid` = 1.
  - `cpu_do` and `host_rdata` hold their values otherwise.
- **Stalled CPU read.** During a stalled slot the 6502 holds its address. On the next cycle the counter is 0, so the CPU wins.
- **Reset.**
  - Asynchronous reset clears `starve_cnt`, sets `rd_own_q`=NONE, and clears `cpu_do` and `host_rdata` to 0.
  - While `rst_n`=0 the outputs are `cpu_rdy`=1, `host_ack`=0, `host_rvalid`=0, and all `dev_*` idle; grants are suppressed.
  - A read pending when reset asserts is dropped: no `rvalid` follows release.

## Timing
- Device access latency is 0: the `dev_*` fields are valid in the slot, sampled by the device at the closing `phi2` edge.
- Read data returns 1 cycle after the slot, for both requesters.
- Host protocol:
  - hold `req`/`we_n`/`a`/`wdata` stable until `ack`;
  - the host may change fields after `ack`;
  - at most one outstanding read;
  - `req` may be reasserted the cycle after `ack`.
- Host worst-case wait while the CPU issues back-to-back reads: `STARVE_LIMIT`+1 cycles from `req` to `ack`.
- Back-to-back grants are allowed. In a host read followed by a CPU read, each returns on its own next cycle; there is no overlap conflict.

## Structure
- Shared package `rriot_pkg`:
  - `owner_t` enum {OWN_NONE, OWN_CPU, OWN_HOST};
  - `RRIOT_AW`=10;
  - `RRIOT_DW`=8.
- No sub-module: one owner mux, one counter, one pending-read register.

## Test plan
- **Reset:** `rst_n`=0 with `host_req`=1 and `cpu_sel`=1 → `cpu_rdy`=1, `host_ack`=0, `dev_cs`=0, `cpu_do`=0.
- **Idle host write:** `cpu_sel`=0, host write a=10'h080, d=8'h5A → same cycle `host_ack`=1, `dev_cs`=1, `dev_we_n`=0, `dev_a`=10'h080, `dev_di`=8'h5A; no `host_rvalid`.
- **Routed reads:** CPU read slot then host read slot, with the device returning 8'h11 then 8'h22 under `dev_oe` → `cpu_do`=8'h11 and `host_rdata`=8'h22 with `host_rvalid` one cycle later; a read with `dev_oe`=0 returns 8'hFF.
- **Forced grant:** `STARVE_LIMIT`=3, CPU reads every cycle, `host_req` held → `host_ack` in the 4th cycle with `cpu_rdy`=0 only then; next cycle `cpu_rdy`=1 and the CPU owns the slot.
- **Write not stolen:** same as above but the CPU writes continuously → `host_ack` stays 0 and the counter stays saturated; `ack` arrives in the first CPU-read slot.
- **Reset mid-read:** reset asserted in the cycle after a granted host read → `host_rvalid` stays 0 through release.
